// File: rtl/fft_mag_sq_pkg.sv
// fft_pkg: shared defaults and the frame FSM state type for the FFT
// magnitude-squared stage.
package fft_pkg;

  localparam int unsigned IN_W_DEF  = 29;
  localparam int unsigned OUT_W_DEF = 2 * IN_W_DEF;
  localparam int unsigned FFT_N_DEF = 1024;
  localparam int unsigned BIN_W_DEF = $clog2(FFT_N_DEF);

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_t;

endpackage

// File: rtl/fft_mag_sq_cplx_mag_sq.sv
// cplx_mag_sq: three-stage re^2 + im^2 pipeline with a valid bit and an
// opaque sideband tag carried alongside the data. Data and tag read as
// zero whenever o_valid is low.
module cplx_mag_sq
  import fft_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned TAG_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic signed [IN_W-1:0] i_re,
  input  logic signed [IN_W-1:0] i_im,
  input  logic [TAG_W-1:0]       i_tag,
  output logic                   o_valid,
  output logic [OUT_W-1:0]       o_data,
  output logic [TAG_W-1:0]       o_tag
);

  logic                   r1_valid;
  logic signed [IN_W-1:0] r1_re;
  logic signed [IN_W-1:0] r1_im;
  logic [TAG_W-1:0]       r1_tag;

  logic                   r2_valid;
  logic [OUT_W-1:0]       r2_re_sq;
  logic [OUT_W-1:0]       r2_im_sq;
  logic [TAG_W-1:0]       r2_tag;

  logic                   r3_valid;
  logic [OUT_W-1:0]       r3_data;
  logic [TAG_W-1:0]       r3_tag;

  // Operands sign-extended to full product width so the low 2*IN_W bits
  // of the product are the exact square.
  logic [2*IN_W-1:0] w_re_ext;
  logic [2*IN_W-1:0] w_im_ext;
  logic [2*IN_W-1:0] w_re_prod;
  logic [2*IN_W-1:0] w_im_prod;

  assign w_re_ext  = {{IN_W{r1_re[IN_W-1]}}, r1_re};
  assign w_im_ext  = {{IN_W{r1_im[IN_W-1]}}, r1_im};
  assign w_re_prod = w_re_ext * w_re_ext;
  assign w_im_prod = w_im_ext * w_im_ext;

  // S1: capture the operands and the tag of an accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_re    <= '0;
      r1_im    <= '0;
      r1_tag   <= '0;
    end else begin
      r1_valid <= i_valid;
      if (i_valid) begin
        r1_re  <= i_re;
        r1_im  <= i_im;
        r1_tag <= i_tag;
      end
    end
  end

  // S2: register both squares.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_re_sq <= '0;
      r2_im_sq <= '0;
      r2_tag   <= '0;
    end else begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_re_sq <= OUT_W'(w_re_prod);
        r2_im_sq <= OUT_W'(w_im_prod);
        r2_tag   <= r1_tag;
      end
    end
  end

  // S3: register the sum; data and tag are zeroed on empty slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r3_valid <= 1'b0;
      r3_data  <= '0;
      r3_tag   <= '0;
    end else begin
      r3_valid <= r2_valid;
      r3_data  <= r2_valid ? (r2_re_sq + r2_im_sq) : '0;
      r3_tag   <= r2_valid ? r2_tag : '0;
    end
  end

  assign o_valid = r3_valid;
  assign o_data  = r3_data;
  assign o_tag   = r3_tag;

endmodule

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: magnitude-squared of FFT output bins with frame tracking.
// Tags each output with its bin index, sop/eop and an abort flag.
// Optional macro PEAK_DETECT_EN adds per-frame peak magnitude/bin outputs.
module fft_mag_sq
  import fft_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned FFT_N = FFT_N_DEF,
  parameter int unsigned BIN_W = $clog2(FFT_N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic                   i_sop,
  input  logic signed [IN_W-1:0] i_re,
  input  logic signed [IN_W-1:0] i_im,
  output logic                   o_valid,
  output logic [OUT_W-1:0]       o_data,
  output logic [BIN_W-1:0]       o_bin,
  output logic                   o_sop,
  output logic                   o_eop,
`ifdef PEAK_DETECT_EN
  output logic                   o_frame_err,
  output logic                   o_peak_valid,
  output logic [OUT_W-1:0]       o_peak_data,
  output logic [BIN_W-1:0]       o_peak_bin
`else
  output logic                   o_frame_err
`endif
);

  localparam int unsigned TAG_W = BIN_W + 3;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_N - 1);

  frame_state_t     r_state;
  logic [BIN_W-1:0] r_cnt;

  logic             w_accept;
  logic [BIN_W-1:0] w_bin;
  logic             w_sop;
  logic             w_eop;
  logic             w_err;
  logic [TAG_W-1:0] w_in_tag;
  logic [TAG_W-1:0] w_out_tag;

  // Acceptance and tags are decided combinationally so the sample enters S1
  // on the same edge the FSM advances.
  assign w_accept = i_valid && (i_sop || (r_state == IN_FRAME));
  assign w_sop    = i_valid && i_sop;
  assign w_err    = i_valid && i_sop && (r_state == IN_FRAME);
  assign w_eop    = w_accept && !i_sop && (r_cnt == LAST_BIN);
  assign w_bin    = i_sop ? '0 : r_cnt;
  assign w_in_tag = {w_bin, w_sop, w_eop, w_err};

  // Frame FSM and bin counter; counter holds through input gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (i_valid) begin
      if (i_sop) begin
        r_state <= IN_FRAME;
        r_cnt   <= BIN_W'(1);
      end else if (r_state == IN_FRAME) begin
        if (r_cnt == LAST_BIN) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + BIN_W'(1);
        end
      end
    end
  end

  cplx_mag_sq #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .TAG_W(TAG_W)
  ) u_mag (
    .clk    (clk),
    .rst    (rst),
    .i_valid(w_accept),
    .i_re   (i_re),
    .i_im   (i_im),
    .i_tag  (w_in_tag),
    .o_valid(o_valid),
    .o_data (o_data),
    .o_tag  (w_out_tag)
  );

  assign {o_bin, o_sop, o_eop, o_frame_err} = w_out_tag;

`ifdef PEAK_DETECT_EN
  logic [OUT_W-1:0] r_pk_data;
  logic [BIN_W-1:0] r_pk_bin;
  logic [OUT_W-1:0] w_pk_data;
  logic [BIN_W-1:0] w_pk_bin;

  // Running max including the current output, so the eop cycle reports a
  // peak that already accounts for the eop sample. sop always reloads,
  // which also restarts the max after an aborted frame.
  always_comb begin
    w_pk_data = r_pk_data;
    w_pk_bin  = r_pk_bin;
    if (o_sop || (o_data > r_pk_data)) begin
      w_pk_data = o_data;
      w_pk_bin  = o_bin;
    end
  end

  // Hold the running max across the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pk_data <= '0;
      r_pk_bin  <= '0;
    end else if (o_valid) begin
      r_pk_data <= w_pk_data;
      r_pk_bin  <= w_pk_bin;
    end
  end

  assign o_peak_valid = o_valid && o_eop;
  assign o_peak_data  = o_peak_valid ? w_pk_data : '0;
  assign o_peak_bin   = o_peak_valid ? w_pk_bin : '0;
`endif

endmodule

// File: tb/tb_fft_mag_sq.sv
// tb_fft_mag_sq: scoreboard bench for fft_mag_sq with FFT_N=8.
// Define PEAK_DETECT_EN to also exercise the peak outputs.
module tb_fft_mag_sq;

  localparam int IN_W  = 29;
  localparam int OUT_W = 58;
  localparam int N     = 8;
  localparam int BW    = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_valid;
  logic                   i_sop;
  logic signed [IN_W-1:0] i_re;
  logic signed [IN_W-1:0] i_im;
  logic                   o_valid;
  logic [OUT_W-1:0]       o_data;
  logic [BW-1:0]          o_bin;
  logic                   o_sop;
  logic                   o_eop;
  logic                   o_frame_err;
`ifdef PEAK_DETECT_EN
  logic                   o_peak_valid;
  logic [OUT_W-1:0]       o_peak_data;
  logic [BW-1:0]          o_peak_bin;
`endif

  fft_mag_sq #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .FFT_N(N),
    .BIN_W(BW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_sop       (i_sop),
    .i_re        (i_re),
    .i_im        (i_im),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_bin       (o_bin),
    .o_sop       (o_sop),
    .o_eop       (o_eop),
`ifdef PEAK_DETECT_EN
    .o_frame_err (o_frame_err),
    .o_peak_valid(o_peak_valid),
    .o_peak_data (o_peak_data),
    .o_peak_bin  (o_peak_bin)
`else
    .o_frame_err (o_frame_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [BW-1:0]    bin;
    logic             sop;
    logic             eop;
    logic             err;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Bench-side frame model
  bit   m_in_frame = 1'b0;
  int   m_cnt      = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint rnd29();
    logic signed [IN_W-1:0] t;
    t = IN_W'($urandom);
    return longint'(t);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Present one input cycle; must be called at a falling edge.
  task automatic send(input bit v, input bit sop, input longint re, input longint im);
    exp_t   e;
    longint sq;
    i_valid = v;
    i_sop   = sop;
    i_re    = re[IN_W-1:0];
    i_im    = im[IN_W-1:0];
    if (v && (sop || m_in_frame)) begin
      sq    = re * re + im * im;
      e.data = sq[OUT_W-1:0];
      e.bin  = sop ? BW'(0) : BW'(m_cnt);
      e.sop  = sop;
      e.err  = sop && m_in_frame;
      e.eop  = !sop && (m_cnt == N - 1);
      e.cyc  = cyc;
      sb.push_back(e);
      if (sop) begin
        m_in_frame = 1'b1;
        m_cnt      = 1;
      end else if (m_cnt == N - 1) begin
        m_in_frame = 1'b0;
        m_cnt      = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_sop   = 1'b0;
  endtask

  task automatic send_frame(input int nbins, input bit gapped);
    for (int b = 0; b < nbins; b++) begin
      send(1'b1, b == 0, rnd29(), rnd29());
      if (gapped) send(1'b0, 1'b1, rnd29(), rnd29());
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    check_eq("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare every output cycle against the scoreboard.
  exp_t             mon_e;
  bit               mon_due;
`ifdef PEAK_DETECT_EN
  logic [OUT_W-1:0] pk_data = '0;
  logic [BW-1:0]    pk_bin  = '0;
  logic [OUT_W-1:0] last_pk_data = '0;
  logic [BW-1:0]    last_pk_bin  = '0;
`endif

  always @(negedge clk) begin
    if (rst) begin
      check_eq("rst_valid", 64'(o_valid), 64'd0);
      check_eq("rst_data", 64'(o_data), 64'd0);
    end else begin
      mon_due = (sb.size() > 0) && (sb[0].cyc + 3 == cyc);
      check_eq("o_valid", 64'(o_valid), 64'(mon_due));
      if (o_valid && mon_due) begin
        mon_e = sb.pop_front();
        check_eq("data", 64'(o_data), 64'(mon_e.data));
        check_eq("bin", 64'(o_bin), 64'(mon_e.bin));
        check_eq("sop", 64'(o_sop), 64'(mon_e.sop));
        check_eq("eop", 64'(o_eop), 64'(mon_e.eop));
        check_eq("frame_err", 64'(o_frame_err), 64'(mon_e.err));
`ifdef PEAK_DETECT_EN
        if (mon_e.sop || mon_e.data > pk_data) begin
          pk_data = mon_e.data;
          pk_bin  = mon_e.bin;
        end
        check_eq("peak_valid", 64'(o_peak_valid), 64'(mon_e.eop));
        if (mon_e.eop) begin
          check_eq("peak_data", 64'(o_peak_data), 64'(pk_data));
          check_eq("peak_bin", 64'(o_peak_bin), 64'(pk_bin));
          last_pk_data = o_peak_data;
          last_pk_bin  = o_peak_bin;
        end
`endif
      end else if (!o_valid) begin
        check_eq("idle_zero", 64'({o_data, o_bin, o_sop, o_eop, o_frame_err}), 64'd0);
`ifdef PEAK_DETECT_EN
        check_eq("idle_peak", 64'({o_peak_valid, o_peak_bin}), 64'd0);
`endif
      end
    end
  end

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_sop   = 1'b0;
    i_re    = '0;
    i_im    = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_valid", 64'(o_valid), 64'd0);
    check_eq("reset_tags", 64'({o_bin, o_sop, o_eop, o_frame_err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Orphan samples with no sop: dropped, no output expected.
    for (int k = 0; k < 4; k++) send(1'b1, 1'b0, 64'sd3, -64'sd4);
    repeat (4) @(negedge clk);

    // Contiguous frame, 3 + j*(-4)... every bin 25.
    for (int b = 0; b < N; b++) send(1'b1, b == 0, 64'sd3, -64'sd4);
    wait_drain();

    // Extremes inside one frame.
    send(1'b1, 1'b1, -(64'sd1 <<< 28), -(64'sd1 <<< 28));
    send(1'b1, 1'b0, (64'sd1 <<< 28) - 1, 64'sd0);
    send(1'b1, 1'b0, 64'sd0, 64'sd0);
    send(1'b1, 1'b0, -(64'sd1 <<< 28), (64'sd1 <<< 28) - 1);
    for (int b = 4; b < N; b++) send(1'b1, 1'b0, rnd29(), rnd29());
    wait_drain();

    // Gapped frame; gap cycles carry a stray unqualified sop.
    send_frame(N, 1'b1);
    wait_drain();

    // Aborted frame: 5 bins, then a new complete frame.
    send_frame(5, 1'b0);
    send_frame(N, 1'b0);
    wait_drain();

    // Reset after bin 4; in-flight outputs are discarded.
    send_frame(5, 1'b0);
    #2;
    rst = 1'b1;
    sb.delete();
    m_in_frame = 1'b0;
    m_cnt      = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) send(1'b1, 1'b0, 64'sd1, 64'sd1);
    send_frame(N, 1'b0);
    wait_drain();

    // Back-to-back random frames with random gaps.
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < N; b++) begin
        send(1'b1, b == 0, rnd29(), rnd29());
        if ($urandom_range(0, 2) == 0) send(1'b0, 1'b0, 64'sd0, 64'sd0);
      end
    end
    wait_drain();

`ifdef PEAK_DETECT_EN
    // Magnitudes {5,9,2,9,1,0,4,8}; 3 and 7 are not sums of two squares,
    // so the last two differ from the nominal list without changing the peak.
    send(1'b1, 1'b1, 64'sd1, 64'sd2);
    send(1'b1, 1'b0, 64'sd3, 64'sd0);
    send(1'b1, 1'b0, 64'sd1, -64'sd1);
    send(1'b1, 1'b0, 64'sd0, -64'sd3);
    send(1'b1, 1'b0, -64'sd1, 64'sd0);
    send(1'b1, 1'b0, 64'sd0, 64'sd0);
    send(1'b1, 1'b0, 64'sd2, 64'sd0);
    send(1'b1, 1'b0, 64'sd2, 64'sd2);
    wait_drain();
    check_eq("peak_frame_data", 64'(last_pk_data), 64'd9);
    check_eq("peak_frame_bin", 64'(last_pk_bin), 64'd1);
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
